// File: rtl/rob_alloc_ctrl_if.sv
// Decode/ROB-facing bundle for the ROB allocation controller.
// Carries slot requests, commit/exception reports and flush/occupancy status.
// master = decode/ROB side driving requests, slave = the controller itself.
interface rob_alloc_ctrl_if #(
    parameter int ROB_IDX_BITS = 4,
    parameter int ARCH_BITS    = 32
);
    // Decode-side slot request and the controller's answer
    logic                    allocReq;
    logic                    allocGrant;
    logic [ROB_IDX_BITS-1:0] allocIdx;

    // Retirement reports from the ROB head
    logic                    commit;
    logic                    except;
    logic [ARCH_BITS-1:0]    exceptPc;

    // Flush sequencing towards the ROB and the front end
    logic                    clear;
    logic                    redirectValid;
    logic [ARCH_BITS-1:0]    redirectPc;

    // Occupancy and error status
    logic [ROB_IDX_BITS:0]   count;
    logic                    full;
    logic                    empty;
    logic                    underflow;

    modport master (
        output allocReq, commit, except, exceptPc,
        input  allocGrant, allocIdx, clear, redirectValid, redirectPc,
               count, full, empty, underflow
    );

    modport slave (
        input  allocReq, commit, except, exceptPc,
        output allocGrant, allocIdx, clear, redirectValid, redirectPc,
               count, full, empty, underflow
    );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// Purpose: hands out ROB slots in program order, mirrors the head and sequences exception flushes.
// Latency: grant/index are combinational from allocReq; status, clear and redirect are registered.
// Backpressure: allocGrant drops while the ROB is full or a flush is in progress; commits never stall.
module rob_alloc_ctrl #(
    parameter int ROB_SLOTS    = 16,
    parameter int ROB_IDX_BITS = 4,
    parameter int ARCH_BITS    = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    rob_alloc_ctrl_if.slave     bus
);

    localparam int CNT_W = ROB_IDX_BITS + 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [CNT_W-1:0] SLOTS_C    = CNT_W'(ROB_SLOTS);
    localparam logic [7:0]       FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    logic [0:0]              state_q,     state_d;
    logic [ROB_IDX_BITS-1:0] tail_q,      tail_d;
    logic [ROB_IDX_BITS-1:0] head_q,      head_d;
    logic [CNT_W-1:0]        count_q,     count_d;
    logic                    clear_q,     clear_d;
    logic                    redir_vld_q, redir_vld_d;
    logic [ARCH_BITS-1:0]    redir_pc_q,  redir_pc_d;
    logic                    underflow_q, underflow_d;
    logic [7:0]              flush_cnt_q, flush_cnt_d;

    logic in_run;
    logic full;
    logic empty;
    logic grant;
    logic retire;
    logic exc_take;

    // Handshake qualification: grant never looks at a same-cycle commit, so a full ROB stays closed
    always_comb begin
        in_run   = (state_q == ST_RUN);
        full     = (count_q == SLOTS_C);
        empty    = (count_q == '0);
        grant    = in_run & bus.allocReq & ~full;
        exc_take = in_run & bus.commit & bus.except;
        retire   = in_run & bus.commit & ~bus.except & ~empty;
    end

    // Next-state: normal pointer/occupancy tracking in RUN, countdown and redirect timing in FLUSH
    always_comb begin
        state_d     = state_q;
        tail_d      = tail_q;
        head_d      = head_q;
        count_d     = count_q;
        clear_d     = 1'b0;
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;
        underflow_d = underflow_q;
        flush_cnt_d = flush_cnt_q;

        if (state_q == ST_RUN) begin
            // A commit against an empty ROB indicates an upstream bookkeeping bug; keep it visible
            if (bus.commit && empty) begin
                underflow_d = 1'b1;
            end

            if (exc_take) begin
                // Any slot granted this cycle is wiped by the clear, so pointers restart at zero
                state_d     = ST_FLUSH;
                clear_d     = 1'b1;
                tail_d      = '0;
                head_d      = '0;
                count_d     = '0;
                redir_pc_d  = bus.exceptPc;
                flush_cnt_d = FLUSH_LAST;
                // A one-cycle flush makes the entry cycle also the last flush cycle
                redir_vld_d = (FLUSH_CYCLES == 1);
            end else begin
                tail_d  = tail_q + ROB_IDX_BITS'(grant);
                head_d  = head_q + ROB_IDX_BITS'(retire);
                count_d = count_q + CNT_W'(grant) - CNT_W'(retire);
            end
        end else begin
            // Commits/exceptions are ignored here; the ROB is being cleared underneath us
            if (flush_cnt_q == 8'd0) begin
                state_d = ST_RUN;
            end else begin
                flush_cnt_d = flush_cnt_q - 8'd1;
            end
            // Raise redirect for the final flush cycle, i.e. when the counter is about to hit zero
            redir_vld_d = (flush_cnt_q == 8'd1);
        end
    end

    // State registers; a reset mid-flush simply abandons the sequence
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            tail_q      <= '0;
            head_q      <= '0;
            count_q     <= '0;
            clear_q     <= 1'b0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            underflow_q <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tail_q      <= tail_d;
            head_q      <= head_d;
            count_q     <= count_d;
            clear_q     <= clear_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            underflow_q <= underflow_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Output drive
    always_comb begin
        bus.allocGrant    = grant;
        bus.allocIdx      = tail_q;
        bus.clear         = clear_q;
        bus.redirectValid = redir_vld_q;
        bus.redirectPc    = redir_pc_q;
        bus.count         = count_q;
        bus.full          = full;
        bus.empty         = empty;
        bus.underflow     = underflow_q;
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl (16 slots, FLUSH_CYCLES=2).
// Inputs change 1 time unit after a rising edge; combinational outputs are sampled 1 unit later,
// registered outputs 1 unit after the edge.
module tb_rob_alloc_ctrl;

    localparam int ROB_SLOTS    = 16;
    localparam int ROB_IDX_BITS = 4;
    localparam int ARCH_BITS    = 32;
    localparam int FLUSH_CYCLES = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rob_alloc_ctrl_if #(.ROB_IDX_BITS(ROB_IDX_BITS), .ARCH_BITS(ARCH_BITS)) bus ();

    rob_alloc_ctrl #(
        .ROB_SLOTS   (ROB_SLOTS),
        .ROB_IDX_BITS(ROB_IDX_BITS),
        .ARCH_BITS   (ARCH_BITS),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst          = 1'b0;
        bus.allocReq = 1'b0;
        bus.commit   = 1'b0;
        bus.except   = 1'b0;
        bus.exceptPc = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk("rst_count",     64'(bus.count), 64'd0);
        chk("rst_empty",     64'(bus.empty), 64'd1);
        chk("rst_full",      64'(bus.full), 64'd0);
        chk("rst_grant",     64'(bus.allocGrant), 64'd0);
        chk("rst_idx",       64'(bus.allocIdx), 64'd0);
        chk("rst_clear",     64'(bus.clear), 64'd0);
        chk("rst_redir_vld", 64'(bus.redirectValid), 64'd0);
        chk("rst_redir_pc",  64'(bus.redirectPc), 64'd0);
        chk("rst_underflow", 64'(bus.underflow), 64'd0);

        // Fill all 16 slots in order, then confirm the 17th request is refused
        bus.allocReq = 1'b1;
        for (int i = 0; i < ROB_SLOTS; i++) begin
            settle();
            chk($sformatf("fill_grant_%0d", i), 64'(bus.allocGrant), 64'd1);
            chk($sformatf("fill_idx_%0d", i),   64'(bus.allocIdx), 64'(i));
            tick();
        end
        settle();
        chk("full_count", 64'(bus.count), 64'd16);
        chk("full_full",  64'(bus.full), 64'd1);
        chk("full_empty", 64'(bus.empty), 64'd0);
        chk("full_grant", 64'(bus.allocGrant), 64'd0);
        chk("full_idx",   64'(bus.allocIdx), 64'd0);

        // Full with simultaneous commit: no bypass, occupancy drops by one
        bus.commit = 1'b1;
        settle();
        chk("nobypass_grant", 64'(bus.allocGrant), 64'd0);
        tick();
        chk("nobypass_count", 64'(bus.count), 64'd15);
        chk("nobypass_full",  64'(bus.full), 64'd0);
        bus.commit = 1'b0;
        settle();
        chk("wrap_grant", 64'(bus.allocGrant), 64'd1);
        chk("wrap_idx",   64'(bus.allocIdx), 64'd0);
        tick();
        chk("wrap_count", 64'(bus.count), 64'd16);
        bus.allocReq = 1'b0;

        // Fresh start, occupancy 5, then 10 cycles of grant+commit
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.allocReq = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("five_count", 64'(bus.count), 64'd5);
        bus.commit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("steady_grant_%0d", i), 64'(bus.allocGrant), 64'd1);
            chk($sformatf("steady_idx_%0d", i),   64'(bus.allocIdx), 64'(5 + i));
            tick();
            chk($sformatf("steady_count_%0d", i), 64'(bus.count), 64'd5);
        end
        chk("steady_underflow", 64'(bus.underflow), 64'd0);

        // Drain to empty, then commit while empty
        bus.allocReq = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("drain_count", 64'(bus.count), 64'd0);
        chk("drain_empty", 64'(bus.empty), 64'd1);
        chk("drain_underflow", 64'(bus.underflow), 64'd0);
        tick();
        chk("uf_count", 64'(bus.count), 64'd0);
        chk("uf_flag",  64'(bus.underflow), 64'd1);
        bus.commit = 1'b0;

        // Later traffic keeps underflow set; build occupancy to 7
        bus.allocReq = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus.allocReq = 1'b0;
        chk("pre_exc_count",     64'(bus.count), 64'd7);
        chk("uf_sticky_traffic", 64'(bus.underflow), 64'd1);

        // except without commit is ignored
        bus.except = 1'b1;
        bus.exceptPc = 32'hDEAD0000;
        tick();
        chk("lone_except_clear", 64'(bus.clear), 64'd0);
        chk("lone_except_count", 64'(bus.count), 64'd7);

        // Committed exception with a request in the same cycle
        bus.allocReq = 1'b1;
        bus.commit   = 1'b1;
        bus.exceptPc = 32'h00001040;
        settle();
        chk("exc_cycle_grant", 64'(bus.allocGrant), 64'd1);
        tick();
        // First flush cycle; a further exception report must be ignored
        bus.exceptPc = 32'h0000BEEF;
        settle();
        chk("f1_clear",     64'(bus.clear), 64'd1);
        chk("f1_count",     64'(bus.count), 64'd0);
        chk("f1_redir_pc",  64'(bus.redirectPc), 64'h00001040);
        chk("f1_redir_vld", 64'(bus.redirectValid), 64'd0);
        chk("f1_grant",     64'(bus.allocGrant), 64'd0);
        tick();
        bus.commit = 1'b0;
        bus.except = 1'b0;
        settle();
        chk("f2_clear",     64'(bus.clear), 64'd0);
        chk("f2_redir_vld", 64'(bus.redirectValid), 64'd1);
        chk("f2_redir_pc",  64'(bus.redirectPc), 64'h00001040);
        chk("f2_grant",     64'(bus.allocGrant), 64'd0);
        chk("f2_count",     64'(bus.count), 64'd0);
        tick();
        settle();
        chk("resume_redir_vld", 64'(bus.redirectValid), 64'd0);
        chk("resume_grant",     64'(bus.allocGrant), 64'd1);
        chk("resume_idx",       64'(bus.allocIdx), 64'd0);
        chk("uf_sticky_flush",  64'(bus.underflow), 64'd1);
        tick();
        chk("resume_count", 64'(bus.count), 64'd1);

        // Reset during a flush
        bus.allocReq = 1'b0;
        bus.commit   = 1'b1;
        bus.except   = 1'b1;
        bus.exceptPc = 32'h00002000;
        tick();
        bus.commit = 1'b0;
        bus.except = 1'b0;
        bus.allocReq = 1'b1;
        settle();
        chk("rf_clear",    64'(bus.clear), 64'd1);
        chk("rf_redir_pc", 64'(bus.redirectPc), 64'h00002000);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        chk("rf_clear_after",    64'(bus.clear), 64'd0);
        chk("rf_redir_vld",      64'(bus.redirectValid), 64'd0);
        chk("rf_redir_pc_after", 64'(bus.redirectPc), 64'd0);
        chk("rf_count",          64'(bus.count), 64'd0);
        chk("rf_underflow",      64'(bus.underflow), 64'd0);
        chk("rf_grant",          64'(bus.allocGrant), 64'd1);
        chk("rf_idx",            64'(bus.allocIdx), 64'd0);
        tick();
        chk("rf_count_post", 64'(bus.count), 64'd1);
        bus.allocReq = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
